vga_scanout_ctrl: RTL and testbench
===================================

# vga_scanout_ctrl

Timing generator and framebuffer scheduler for the VGA output path. Produces hsync/vsync and sequences pixel reads from a single-port, synchronous-read framebuffer RAM. Shares that RAM with one pixel writer, giving scanout absolute priority. Sits between the framebuffer and the `{hsync, vsync, r, g, b}` output bus of `main`.

## Interface
- H_ACTIVE, 640, visible pixels per line
- H_FP / H_SYNC / H_BP, 16 / 96 / 48, horizontal porch and sync lengths (cycles)
- V_ACTIVE, 480, visible lines per frame
- V_FP / V_SYNC / V_BP, 10 / 2 / 33, vertical porch and sync lengths (lines)
- SYNC_POL, 0, sync pulse level (0 = active-low)
- ADDR_W, 19, framebuffer address width; must satisfy 2^ADDR_W ≥ H_ACTIVE*V_ACTIVE

Ports:
- _i_clk  in  1  pixel clock
- _i_rst_n  in  1  asynchronous, active-low reset
- _i_wr_valid  in  1  writer request
- _i_wr_addr  in  ADDR_W  writer linear pixel address
- _i_wr_data  in  3  writer pixel {r,g,b}
- _o_wr_ready  out  1  writer may transfer this cycle
- _o_mem_addr  out  ADDR_W  RAM address
- _o_mem_we  out  1  RAM write enable
- _o_mem_wdata  out  3  RAM write data
- _i_mem_rdata  in  3  RAM read data, valid one cycle after address
- _o_vga  out  5  {hsync, vsync, r, g, b}

## Operation
- hcnt counts 0..H_TOTAL-1 (H_TOTAL = sum of H params); on wrap, vcnt counts 0..V_TOTAL-1.
- Regions: active hcnt < H_ACTIVE; sync when H_ACTIVE+H_FP ≤ hcnt < H_ACTIVE+H_FP+H_SYNC. Same for vcnt.
- Scan slot: hcnt and vcnt both active. Drive _o_mem_addr = scan pointer, _o_mem_we = 0, then increment the pointer. Pointer resets to 0 when hcnt = vcnt = 0; no multiplier.
- Non-scan slot: _o_wr_ready = 1. On valid && ready, drive the writer address and data.
  - If the address is < H_ACTIVE*V_ACTIVE: _o_mem_we = 1.
  - Otherwise the transfer is accepted with _o_mem_we = 0 (silently dropped).
- _o_wr_ready is decoded from registered counters only and never depends on _i_wr_valid. The writer must hold valid, addr and data stable until ready.
- Pixel colour: _i_mem_rdata when the delayed active flag is set, else 000.

## Timing
- Counter position at cycle t appears on _o_vga at cycle t+2:
  - t: address issued
  - t+1: rdata sampled into the output register
  - t+2: visible on _o_vga
- Sync and active flags pass through a matching 2-stage delay.
- _o_mem_addr, _o_mem_we and _o_mem_wdata are combinational from counters and writer inputs.
- Reset (asynchronous assert, synchronous release):
  - hcnt = vcnt = 0, pointer = 0, delay pipes cleared.
  - _o_vga = {~SYNC_POL, ~SYNC_POL, 000}.
  - _o_mem_we = 0, _o_wr_ready = 0.
- Reset mid-frame restarts at hcnt = vcnt = 0. No write is issued while reset is held.
- Wrap-around: hcnt and vcnt wrap simultaneously at frame end. The pointer reset and the next scan read occur in the same cycle.

## Structure
- Package vga_pkg holds:
  - default timing constants
  - typedef rgb_t (3 bits)
  - function deriving H_TOTAL, V_TOTAL and frame pixel count
- Sub-module vga_axis_counter (ACTIVE, FP, SYNC, BP parameters):
  - inputs: count enable
  - outputs: count, active, sync, wrap
  - one instance per axis; the vertical instance is enabled by the horizontal wrap.

## Test plan
All scenarios use small timing:
- H_ACTIVE=4, H_FP=1, H_SYNC=2, H_BP=1 (H_TOTAL=8)
- V_ACTIVE=3, V_FP=1, V_SYNC=1, V_BP=1 (V_TOTAL=6)
- 48 cycles per frame; cycle 0 = first cycle after reset release.

Scenarios:
- Sync timing: idle writer, no memory traffic. Expect hsync low at cycles 7–8 of every line and vsync low on cycles 34–41. Both high at all other times.
- Scanout order: RAM preloaded with data[k] = k mod 8. Expect rgb = 0,1,2,3 on cycles 2–5 and 4,5,6,7 on cycles 10–13. Expect rgb = 000 in blanking.
- Write arbitration: wr_valid held from cycle 0 with addr 5, data 7. Expect:
  - ready = 0 on cycles 0–3; accept at cycle 4 with mem_we = 1, mem_addr = 5.
  - rgb = 7 on cycle 59 of the next frame.
- Vblank burst: 24 back-to-back writes starting at cycle 24. Expect ready = 1 for every cycle 24–47 and all 24 accepted, one per cycle.
- Out-of-range write: addr 12 offered at cycle 4. Expect ready = 1 and accept, mem_we = 0, RAM unchanged.
- Mid-frame reset: drop _i_rst_n at cycle 20. Expect outputs idle immediately, with no clock edge needed. After release, the sync pattern restarts exactly as in the sync-timing scenario.

Source files
------------

// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared timing defaults, pixel type and derived-size helpers
package vga_pkg;

  localparam int   H_ACTIVE_DEF = 640;
  localparam int   H_FP_DEF     = 16;
  localparam int   H_SYNC_DEF   = 96;
  localparam int   H_BP_DEF     = 48;
  localparam int   V_ACTIVE_DEF = 480;
  localparam int   V_FP_DEF     = 10;
  localparam int   V_SYNC_DEF   = 2;
  localparam int   V_BP_DEF     = 33;
  localparam logic SYNC_POL_DEF = 1'b0;
  localparam int   ADDR_W_DEF   = 19;

  typedef logic [2:0] rgb_t;

  // Total length of one axis (line in cycles, or frame in lines).
  function automatic int axis_total(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

  // Number of addressable pixels in the visible frame.
  function automatic int frame_pixels(input int h_active, input int v_active);
    return h_active * v_active;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// rtl/vga_axis_counter.sv - one timing axis: position counter with active/sync decode
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = H_ACTIVE_DEF,
  parameter int FP     = H_FP_DEF,
  parameter int SYNC   = H_SYNC_DEF,
  parameter int BP     = H_BP_DEF,
  parameter int CW     = $clog2(axis_total(ACTIVE, FP, SYNC, BP))
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  output logic [CW-1:0] count,
  output logic          active,
  output logic          sync,
  output logic          wrap
);

  localparam int            TOTAL    = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CW-1:0] LAST     = CW'(TOTAL - 1);
  localparam logic [CW-1:0] ACT_END  = CW'(ACTIVE);
  localparam logic [CW-1:0] SYNC_BEG = CW'(ACTIVE + FP);
  localparam logic [CW-1:0] SYNC_END = CW'(ACTIVE + FP + SYNC);

  logic [CW-1:0] count_q, count_d;

  // Advance when enabled, returning to zero after the last position of the axis.
  always_comb begin
    count_d = count_q;
    if (en) begin
      count_d = (count_q == LAST) ? '0 : count_q + CW'(1);
    end
  end

  // Position register; reset restarts the axis at zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count  = count_q;
  assign active = (count_q < ACT_END);
  assign sync   = (count_q >= SYNC_BEG) && (count_q < SYNC_END);
  assign wrap   = en && (count_q == LAST);

endmodule

// File: rtl/vga_scanout_ctrl.sv
// rtl/vga_scanout_ctrl.sv - VGA timing, framebuffer scanout and writer arbitration
module vga_scanout_ctrl
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = H_ACTIVE_DEF,
  parameter int   H_FP     = H_FP_DEF,
  parameter int   H_SYNC   = H_SYNC_DEF,
  parameter int   H_BP     = H_BP_DEF,
  parameter int   V_ACTIVE = V_ACTIVE_DEF,
  parameter int   V_FP     = V_FP_DEF,
  parameter int   V_SYNC   = V_SYNC_DEF,
  parameter int   V_BP     = V_BP_DEF,
  parameter logic SYNC_POL = SYNC_POL_DEF,
  parameter int   ADDR_W   = ADDR_W_DEF
) (
  input  logic              _i_clk,
  input  logic              _i_rst_n,
  input  logic              _i_wr_valid,
  input  logic [ADDR_W-1:0] _i_wr_addr,
  input  logic [2:0]        _i_wr_data,
  output logic              _o_wr_ready,
  output logic [ADDR_W-1:0] _o_mem_addr,
  output logic              _o_mem_we,
  output logic [2:0]        _o_mem_wdata,
  input  logic [2:0]        _i_mem_rdata,
  output logic [4:0]        _o_vga
);

  localparam int HCW = $clog2(axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP));
  localparam int VCW = $clog2(axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP));
  localparam logic [ADDR_W:0] FRAME_PIX = (ADDR_W + 1)'(frame_pixels(H_ACTIVE, V_ACTIVE));

  logic [HCW-1:0] hcnt;
  logic [VCW-1:0] vcnt;
  logic           h_act, h_sync, h_wrap;
  logic           v_act, v_sync, v_wrap;
  logic           unused_v_wrap;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP), .CW(HCW)
  ) u_h_axis (
    .clk(_i_clk), .rst_n(_i_rst_n), .en(1'b1),
    .count(hcnt), .active(h_act), .sync(h_sync), .wrap(h_wrap)
  );

  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP), .CW(VCW)
  ) u_v_axis (
    .clk(_i_clk), .rst_n(_i_rst_n), .en(h_wrap),
    .count(vcnt), .active(v_act), .sync(v_sync), .wrap(v_wrap)
  );

  assign unused_v_wrap = v_wrap;

  logic              scan, frame_start, wr_in_range;
  logic [ADDR_W-1:0] scan_addr;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic              hs1_q, hs1_d, vs1_q, vs1_d, act1_q, act1_d;
  logic [4:0]        vga_q, vga_d;
  rgb_t              pix;

  // Scan pointer: forced to zero at the first pixel of a frame so the wrap cycle
  // itself reads address 0, then steps once per scan slot.
  always_comb begin
    scan        = h_act && v_act;
    frame_start = (hcnt == '0) && (vcnt == '0);
    scan_addr   = frame_start ? '0 : ptr_q;
    ptr_d       = scan ? scan_addr + ADDR_W'(1) : ptr_q;
  end

  // RAM port mux: scanout owns the port in scan slots, the writer gets every other slot.
  always_comb begin
    wr_in_range  = ({1'b0, _i_wr_addr} < FRAME_PIX);
    _o_wr_ready  = _i_rst_n && !scan;
    _o_mem_addr  = scan ? scan_addr : _i_wr_addr;
    _o_mem_we    = _o_wr_ready && _i_wr_valid && wr_in_range;
    _o_mem_wdata = _i_wr_data;
  end

  // Two-stage delay: stage 1 aligns flags with returning read data, stage 2 is the output.
  always_comb begin
    hs1_d  = h_sync ? SYNC_POL : ~SYNC_POL;
    vs1_d  = v_sync ? SYNC_POL : ~SYNC_POL;
    act1_d = scan;
    pix    = act1_q ? rgb_t'(_i_mem_rdata) : rgb_t'(3'b000);
    vga_d  = {hs1_q, vs1_q, pix};
  end

  // Pointer and delay-pipe registers; reset leaves syncs inactive and colour black.
  always_ff @(posedge _i_clk or negedge _i_rst_n) begin
    if (!_i_rst_n) begin
      ptr_q  <= '0;
      hs1_q  <= ~SYNC_POL;
      vs1_q  <= ~SYNC_POL;
      act1_q <= 1'b0;
      vga_q  <= {~SYNC_POL, ~SYNC_POL, 3'b000};
    end else begin
      ptr_q  <= ptr_d;
      hs1_q  <= hs1_d;
      vs1_q  <= vs1_d;
      act1_q <= act1_d;
      vga_q  <= vga_d;
    end
  end

  assign _o_vga = vga_q;

endmodule

// File: tb/tb_vga_scanout_ctrl.sv
// tb/tb_vga_scanout_ctrl.sv - scoreboard bench for vga_scanout_ctrl on a small timing
module tb_vga_scanout_ctrl;

  localparam int         HT   = 8;
  localparam int         VT   = 6;
  localparam logic [4:0] IDLE = 5'b11000;

  typedef struct {
    int         due;
    logic [4:0] val;
  } sb_t;

  typedef struct {
    int         start;
    logic [3:0] addr;
    logic [2:0] data;
  } wr_t;

  logic       clk;
  logic       rst_n;
  logic       wr_valid;
  logic [3:0] wr_addr;
  logic [2:0] wr_data;
  logic       wr_ready;
  logic [3:0] mem_addr;
  logic       mem_we;
  logic [2:0] mem_wdata;
  logic [2:0] mem_rdata;
  logic [4:0] vga;

  logic [2:0] ram     [16];
  logic [2:0] ref_mem [16];
  logic [4:0] vga_log [128];

  sb_t sb_q[$];
  wr_t wq[$];
  int  acc_q[$];
  int  checks;
  int  errors;

  vga_scanout_ctrl #(
    .H_ACTIVE(4), .H_FP(1), .H_SYNC(2), .H_BP(1),
    .V_ACTIVE(3), .V_FP(1), .V_SYNC(1), .V_BP(1),
    .SYNC_POL(1'b0), .ADDR_W(4)
  ) dut (
    ._i_clk(clk),
    ._i_rst_n(rst_n),
    ._i_wr_valid(wr_valid),
    ._i_wr_addr(wr_addr),
    ._i_wr_data(wr_data),
    ._o_wr_ready(wr_ready),
    ._o_mem_addr(mem_addr),
    ._o_mem_we(mem_we),
    ._o_mem_wdata(mem_wdata),
    ._i_mem_rdata(mem_rdata),
    ._o_vga(vga)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Single-port synchronous-read framebuffer model.
  always @(posedge clk) begin
    if (mem_we) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end

  task automatic check(input string tag, input int obs, input int exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n    = 1'b0;
    wr_valid = 1'b1;
    wr_addr  = 4'd0;
    wr_data  = 3'd6;
    #1;
    check("rst_vga", vga, IDLE);
    check("rst_ready", wr_ready, 0);
    repeat (3) begin
      @(negedge clk);
      #1;
      check("rst_we", mem_we, 0);
      check("rst_vga_hold", vga, IDLE);
    end
    wr_valid = 1'b0;
    sb_q.delete();
    wq.delete();
    acc_q.delete();
    sb_q.push_back('{0, IDLE});
    sb_q.push_back('{1, IDLE});
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic run(input int ncyc, input int drop_at);
    for (int c = 0; c < ncyc; c++) begin
      int         hc, vc, idx;
      logic       scan, hs, vs, have_w;
      logic [2:0] pix;
      wr_t        w;
      if (c > 0) @(negedge clk);
      hc     = c % HT;
      vc     = (c / HT) % VT;
      scan   = (hc < 4) && (vc < 3);
      idx    = vc * 4 + hc;
      have_w = (wq.size() > 0) && (wq[0].start <= c);
      if (have_w) begin
        w        = wq[0];
        wr_valid = 1'b1;
        wr_addr  = w.addr;
        wr_data  = w.data;
      end else begin
        wr_valid = 1'b0;
        wr_addr  = 4'd0;
        wr_data  = 3'd0;
      end
      #1;
      check($sformatf("ready@%0d", c), wr_ready, !scan);
      if (scan) begin
        check($sformatf("scan_addr@%0d", c), mem_addr, idx);
        check($sformatf("scan_we@%0d", c), mem_we, 0);
      end else if (have_w) begin
        check($sformatf("wr_addr@%0d", c), mem_addr, w.addr);
        check($sformatf("wr_we@%0d", c), mem_we, (w.addr < 12));
        check($sformatf("wr_data@%0d", c), mem_wdata, w.data);
        if (w.addr < 12) ref_mem[w.addr] = w.data;
        acc_q.push_back(c);
        void'(wq.pop_front());
      end else begin
        check($sformatf("idle_we@%0d", c), mem_we, 0);
      end
      hs  = !((hc >= 5) && (hc < 7));
      vs  = !(vc == 4);
      pix = scan ? ref_mem[idx] : 3'd0;
      sb_q.push_back('{c + 2, {hs, vs, pix}});
      while ((sb_q.size() > 0) && (sb_q[0].due == c)) begin
        check($sformatf("vga@%0d", c), vga, sb_q[0].val);
        void'(sb_q.pop_front());
      end
      if (c < 128) vga_log[c] = vga;
      if (c == drop_at) begin
        #1;
        rst_n = 1'b0;
        #1;
        check("drop_vga", vga, IDLE);
        check("drop_ready", wr_ready, 0);
        check("drop_we", mem_we, 0);
        return;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired checks=%0d", checks);
    $fatal(1);
  end

  initial begin
    checks   = 0;
    errors   = 0;
    rst_n    = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = 4'd0;
    wr_data  = 3'd0;
    for (int k = 0; k < 16; k++) begin
      ram[k]     = 3'(k % 8);
      ref_mem[k] = 3'(k % 8);
    end

    // Sync timing and scanout order over two frames.
    do_reset();
    run(96, -1);
    for (int c = 2; c <= 5; c++) check($sformatf("order0@%0d", c), vga_log[c][2:0], c - 2);
    for (int c = 10; c <= 13; c++) check($sformatf("order1@%0d", c), vga_log[c][2:0], c - 6);
    check("blank6", vga_log[6][2:0], 0);
    check("hs7", vga_log[7][4], 0);
    check("hs9", vga_log[9][4], 1);
    check("vs33", vga_log[33][3], 1);
    check("vs34", vga_log[34][3], 0);
    check("vs41", vga_log[41][3], 0);
    check("vs42", vga_log[42][3], 1);

    // Writer held from cycle 0 waits for the first non-scan slot.
    do_reset();
    wq.push_back('{0, 4'd5, 3'd7});
    run(64, -1);
    check("arb_count", acc_q.size(), 1);
    if (acc_q.size() > 0) check("arb_cycle", acc_q[0], 4);
    check("arb_px59", vga_log[59][2:0], 7);

    // Vblank burst: one accept per cycle for lines 3..5.
    do_reset();
    for (int k = 0; k < 24; k++) wq.push_back('{24, 4'(k % 12), 3'((k * 3 + 1) % 8)});
    run(72, -1);
    check("burst_count", acc_q.size(), 24);
    if (acc_q.size() == 24) begin
      check("burst_first", acc_q[0], 24);
      check("burst_last", acc_q[23], 47);
    end

    // Out-of-range write is accepted but not stored.
    do_reset();
    wq.push_back('{4, 4'd12, 3'd5});
    run(16, -1);
    check("oob_count", acc_q.size(), 1);
    if (acc_q.size() > 0) check("oob_cycle", acc_q[0], 4);
    check("oob_ram", ram[12], 4);

    // Mid-frame reset, then the sync pattern restarts from scratch.
    do_reset();
    run(21, 20);
    do_reset();
    run(48, -1);
    check("re_hs7", vga_log[7][4], 0);
    check("re_hs15", vga_log[15][4], 0);
    check("re_vs34", vga_log[34][3], 0);
    check("re_vs33", vga_log[33][3], 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
